uart_isa_core: RTL

UART_ISA_CORE -- requirements
Module: uart_isa_core

---
 rtl/uart_isa_core.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_isa_core.sv
// uart_isa_core: byte-stream register machine fed through a FIFO, with a display handshake.
// Define UART_ISA_SUB_EN to enable opcode 4 (SUB); without it opcode 4 is illegal.
module uart_isa_core #(
  parameter int DATA_W = 8,
  parameter int NREG = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic              flag_z,
  output logic              flag_c,
  output logic              err,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(NREG);
  localparam int NB = DATA_W / 8;
`ifdef UART_ISA_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif
  localparam logic [1:0] S_OP = 2'd0, S_ARG = 2'd1, S_IMM = 2'd2, S_DISP = 2'd3;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic push, pop, empty;
  logic [7:0] head;
  logic [1:0] state, cnt;
  logic [3:0] op_q;
  logic [RW-1:0] rd_q;
  logic bad_q;
  logic [DATA_W-1:0] imm, imm_nxt, a, b;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W:0] sum, dif, res;
  logic [3:0] op;
  logic [RW-1:0] hrd, hrs;
  logic rd_bad, rs_bad;

  assign empty = count == '0;
  assign in_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push = in_valid && in_ready;
  assign head = mem[rptr];
  assign pop = !empty && state != S_DISP;
  assign busy = state != S_OP || !empty;

  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end

  assign op = head[7:4];
  assign hrd = head[RW-1:0];
  assign hrs = head[4 +: RW];
  assign rd_bad = 32'(head[3:0]) >= NREG;
  assign rs_bad = 32'(head[7:4]) >= NREG;
  assign a = regs[rd_q];
  assign b = regs[hrs];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign res = op_q == 4'h3 ? sum : dif;
  // immediate bytes arrive little-endian, so each new byte shifts in from the top
  assign imm_nxt = DATA_W'({head, imm} >> 8);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      state <= S_OP;
      op_q <= '0;
      rd_q <= '0;
      bad_q <= 1'b0;
      cnt <= '0;
      imm <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      err <= 1'b0;
    end else if (state == S_DISP) begin
      if (disp_ready) begin
        disp_valid <= 1'b0;
        state <= S_OP;
      end
    end else if (pop) begin
      case (state)
        S_OP: begin
          op_q <= op;
          rd_q <= hrd;
          cnt <= '0;
          imm <= '0;
          bad_q <= rd_bad || (op == 4'h4 && !SUB_EN);
          case (op)
            4'h0: ;
            4'h1: state <= S_IMM;
            4'h2, 4'h3, 4'h4: state <= S_ARG;
            4'h5: if (rd_bad) err <= 1'b1;
                  else begin
                    disp_value <= regs[hrd];
                    disp_valid <= 1'b1;
                    state <= S_DISP;
                  end
            4'h6: if (rd_bad) err <= 1'b1; else regs[hrd] <= '0;
            4'h7: err <= 1'b0;
            default: err <= 1'b1;
          endcase
        end
        S_ARG: begin
          state <= S_OP;
          if (bad_q || rs_bad) err <= 1'b1;
          else if (op_q == 4'h2) regs[rd_q] <= b;
          else begin
            regs[rd_q] <= res[DATA_W-1:0];
            flag_c <= res[DATA_W];
            flag_z <= res[DATA_W-1:0] == '0;
          end
        end
        default: begin
          imm <= imm_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(NB - 1)) begin
            state <= S_OP;
            if (bad_q) err <= 1'b1; else regs[rd_q] <= imm_nxt;
          end
        end
      endcase
    end
endmodule
